// File: rtl/ysyx_25020047_pkg.sv
// ysyx_25020047_pkg: shared LSU state encodings, size codes and op legality check.
package ysyx_25020047_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Both directions at once, odd size codes, or a misaligned word are rejected.
    function automatic logic op_illegal(input logic rd, input logic wr,
                                        input logic [1:0] size, input logic [1:0] lo);
        return (rd && wr) || size[0] || (size == SZ_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_lane.sv
// ysyx_25020047_lsu_lane: byte-lane steering for stores (mask, replication) and byte-load extraction.
module ysyx_25020047_lsu_lane
    import ysyx_25020047_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        wen,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  wmask,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);

    logic is_word;

    assign is_word = (size == SZ_WORD);
    assign wmask   = !wen ? 4'b0000 : (is_word ? 4'b1111 : 4'b0001 << off);
    assign st_word = is_word ? st_data : {4{st_data[7:0]}};
    assign ld_data = is_word ? ld_word : {24'b0, ld_word[{off, 3'b000} +: 8]};

endmodule

// File: rtl/ysyx_25020047_lsu_ctrl.sv
// ysyx_25020047_lsu_ctrl: multi-cycle load/store sequencer with valid/ready memory handshake.
// Optional watchdog abort enabled by defining YSYX_25020047_LSU_TIMEOUT_EN.
module ysyx_25020047_lsu_ctrl
    import ysyx_25020047_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        op_read,
    input  logic        op_write,
    input  logic [1:0]  op_size,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        op_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        timeout,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata
);

    lsu_state_t  state;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        wen;
    logic        hit;
    logic [31:0] ld_data;

    ysyx_25020047_lsu_lane u_lane (
        .size    (size),
        .off     (addr[1:0]),
        .wen     (wen),
        .st_data (wdata),
        .ld_word (mem_resp_rdata),
        .wmask   (mem_req_wmask),
        .st_word (mem_req_wdata),
        .ld_data (ld_data)
    );

`ifdef YSYX_25020047_LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt;
    // Counter is zero throughout IDLE, so it starts at zero on REQ entry.
    always_ff @(posedge clk) begin
        if (rst || state == LSU_IDLE)
            cnt <= '0;
        else if (state == LSU_REQ || state == LSU_WAIT)
            cnt <= cnt + 1'b1;
    end
    assign hit = (state == LSU_REQ || state == LSU_WAIT) && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign hit = 1'b0;
`endif

    assign op_ready      = (state == LSU_IDLE);
    assign busy          = (state != LSU_IDLE);
    assign done          = (state == LSU_DONE);
    assign mem_req_valid = (state == LSU_REQ);
    assign mem_req_addr  = {addr[31:2], 2'b00};
    assign mem_req_wen   = wen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LSU_IDLE;
            addr    <= '0;
            wdata   <= '0;
            size    <= '0;
            wen     <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: if (op_valid && (op_read || op_write)) begin
                    addr  <= op_addr;
                    wdata <= op_wdata;
                    size  <= op_size;
                    wen   <= op_write;
                    if (op_illegal(op_read, op_write, op_size, op_addr[1:0])) begin
                        state <= LSU_DONE;
                        err   <= 1'b1;
                        rdata <= '0;
                    end else begin
                        state <= LSU_REQ;
                    end
                end
                LSU_REQ: if (hit) begin
                    state   <= LSU_DONE;
                    err     <= 1'b1;
                    timeout <= 1'b1;
                    rdata   <= '0;
                end else if (mem_req_ready) begin
                    state <= LSU_WAIT;
                end
                LSU_WAIT: if (hit) begin
                    state   <= LSU_DONE;
                    err     <= 1'b1;
                    timeout <= 1'b1;
                    rdata   <= '0;
                end else if (mem_resp_valid) begin
                    state <= LSU_DONE;
                    rdata <= wen ? 32'b0 : ld_data;
                end
                default: begin
                    state   <= LSU_IDLE;
                    err     <= 1'b0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ysyx_25020047_lsu_ctrl.md
# ysyx_25020047_lsu_ctrl

Multi-cycle load/store sequencer between the EXU and the data-memory port. It accepts one memory operation from the EXU: a word or byte load (lw/lbu) or store (sw/sb), with the effective address computed by the EXU. It drives a valid/ready request and response handshake to memory, aligns byte lanes, and stalls the core via `busy` until the operation completes. It returns load data for writeback and flags illegal or hung accesses.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: cycles spent in REQ+WAIT before the access is aborted (used only with the timeout macro).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  system clock.
  - `rst`  in  1  synchronous active-high reset.
- EXU side:
  - `op_valid`  in  1  EXU presents a memory op.
  - `op_read`  in  1  load.
  - `op_write`  in  1  store.
  - `op_size`  in  2  0 = byte, 2 = word; 1 and 3 are illegal.
  - `op_addr`  in  32  effective address (EXU result).
  - `op_wdata`  in  32  store data (rs2).
  - `op_ready`  out  1  controller idle, accepts op.
  - `busy`  out  1  core stall.
  - `done`  out  1  one-cycle completion pulse.
  - `rdata`  out  32  load result, valid while `done`.
  - `err`  out  1  one-cycle pulse with `done` on illegal or aborted op.
  - `timeout`  out  1  one-cycle pulse with `done` on watchdog abort.
- Memory side:
  - `mem_req_valid`  out  1  request valid.
  - `mem_req_ready`  in  1  request accepted.
  - `mem_req_addr`  out  32  word-aligned address.
  - `mem_req_wen`  out  1  1 = write.
  - `mem_req_wdata`  out  32  lane-replicated store data.
  - `mem_req_wmask`  out  4  byte enables.
  - `mem_resp_valid`  in  1  response or write-ack.
  - `mem_resp_rdata`  in  32  read word.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - `op_ready`=1.
  - On `op_valid && (op_read ^ op_write)` with a legal op, latch op fields and go to REQ.
  - Illegal op: `op_read && op_write`, `op_size` 1/3, or word with `op_addr[1:0]!=0`. Latch the op, go directly to DONE with `err`=1 and `rdata`=0. No memory request is issued.
  - `op_valid` with neither read nor write is ignored.
- REQ: `mem_req_valid`=1, with all request fields held stable until `mem_req_ready`; then go to WAIT.
- WAIT: `mem_resp_valid` is sampled only in this state. On response, capture `rdata` and go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Request fields:
  - Address: `mem_req_addr` = `{addr[31:2],2'b00}`.
  - Word ops: `wmask`=4'b1111, `wdata`=`op_wdata`.
  - Byte ops: `wmask`=4'b0001<<addr[1:0], `wdata`={4{op_wdata[7:0]}}.
  - Loads: `wmask`=0, `wen`=0.
- Load result:
  - Word loads: `rdata`=`mem_resp_rdata`.
  - Byte loads: `rdata` = zero-extended byte `mem_resp_rdata[8*addr[1:0] +: 8]`.
  - Stores: `rdata`=0.
- `busy` = (state != IDLE). `op_ready` = (state == IDLE).

## Timing
- Reset values:
  - State IDLE.
  - `op_ready`=1.
  - All other outputs 0, including `rdata` and all latched fields.
- Best-case latency (ready and response each after one cycle):
  - Accept at T.
  - `mem_req_valid` at T+1 with ready.
  - Response at T+2.
  - `done` at T+3.
  - `op_ready` at T+4.
- Illegal-op latency: accept at T, `done`+`err` at T+1.
- A response in the same cycle as the request handshake is ignored. Memory must respond ≥1 cycle after acceptance.
- A response arriving in IDLE, REQ, or DONE is ignored.
- `rst` mid-operation:
  - Next cycle IDLE, `mem_req_valid`=0.
  - No `done` pulse.
  - The abandoned response is dropped.
- `op_valid` while `busy` is ignored. The EXU must hold the op until `op_ready`.

## Configuration
- Macro: `YSYX_25020047_LSU_TIMEOUT_EN`.
- Defined:
  - An 8+-bit counter clears on entry to REQ and increments in REQ/WAIT.
  - On reaching `TIMEOUT_CYCLES`, drop `mem_req_valid`, go to DONE with `err`=1, `timeout`=1, `rdata`=0.
- Undefined:
  - No counter is built and `timeout` is tied to 0.
  - The controller waits indefinitely.

## Structure
- Shared package/header `ysyx_25020047_pkg`:
  - State encodings LSU_IDLE/LSU_REQ/LSU_WAIT/LSU_DONE.
  - Size codes SZ_BYTE=2'd0, SZ_WORD=2'd2.
- One combinational sub-module, `ysyx_25020047_lsu_lane`: computes wmask/wdata replication and load byte extraction from size, addr[1:0], and data.

## Test plan
- sw to 0x80000010, data 0xDEADBEEF, ready/resp immediate:
  - Expect req addr 0x80000010, wmask 4'hF, wen=1.
  - `done` at T+3, `err`=0.
- lbu from 0x80000003, memory word 0x11223344 → `rdata`=0x00000011.
- sb data 0x000000AB to 0x80000006:
  - Expect wmask 4'b0100, wdata 0xABABABAB, addr 0x80000004.
- lw from 0x80000002:
  - No `mem_req_valid` is ever asserted.
  - `done`+`err` at T+1, `rdata`=0.
- `mem_req_ready` low for 5 cycles: request fields stable throughout, then `rst` asserted in WAIT:
  - IDLE next cycle.
  - A later `mem_resp_valid` produces no `done`.
- With the macro defined, `TIMEOUT_CYCLES`=8 and memory never responding:
  - `done`+`err`+`timeout` pulse 8 cycles after REQ entry.
  - `mem_req_valid` low afterwards.
